// File: rtl/byte_receiver.sv
// -----------------------------------------------------------------------------
// byte_receiver
//
// Inbound JTAG data-register word assembler. Samples TDI once per TCK rising
// edge while the register is selected in Shift-DR, builds WIDTH-bit words
// MSB-first and hands each completed word to the consumer through a
// valid/ack handshake.
//
// Ports
//   i_clk_tck    TCK, all state updates on the rising edge
//   i_reset_n    asynchronous active-low reset
//   i_enable     high while this data register is selected in Shift-DR
//   i_in         TDI serial data, MSB of each word first
//   i_ack        consumer accepts the word on o_out
//   o_out        last completed word
//   o_valid      o_out holds a word not yet acknowledged
//   o_overrun    sticky: a word completed while the previous one was unacked
//   o_aborted    one-cycle pulse: enable dropped with a partial word pending
//   o_bit_count  bits of the current word received so far, 0..WIDTH-1
//
// WIDTH must be in 2..32; bit_count is fixed at 6 bits.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not selected; bit_count is 0 and no partial word is held
// SHIFT | selected; every rising edge samples one bit of the current word
// -----------------------------------------------------------------------------
module byte_receiver #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk_tck,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_in,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_out,
  output logic             o_valid,
  output logic             o_overrun,
  output logic             o_aborted,
  output logic [5:0]       o_bit_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [5:0] LAST_BIT = 6'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_overrun;
  logic             r_aborted;
  logic [5:0]       r_bit_count;

  logic             w_sample;
  logic             w_complete;
  logic             w_abort;
  logic [WIDTH-1:0] w_word;

  // Only WIDTH-1 bits of history are ever needed: the incoming bit is the
  // last one, so the completed word is the history plus the current TDI.
  assign w_word = {r_shift, i_in};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk_tck or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. A sampling edge in IDLE both enters SHIFT and captures
  // the first bit, so there is no dead cycle on entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_enable)  w_state_next = SHIFT;
      SHIFT:   if (!i_enable) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: per-edge actions
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sample   = 1'b0;
    w_complete = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      IDLE: begin
        w_sample   = i_enable;
        // Reachable only for WIDTH==... never: bit_count is 0 in IDLE, so a
        // word cannot complete on the entry edge unless WIDTH were 1.
        w_complete = i_enable && (r_bit_count == LAST_BIT);
      end
      SHIFT: begin
        w_sample   = i_enable;
        w_complete = i_enable && (r_bit_count == LAST_BIT);
        // Leaving with an empty word (right after a completion) is silent.
        w_abort    = !i_enable && (r_bit_count != 6'd0);
      end
      default: begin
        w_sample   = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift register and bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk_tck or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_shift     <= '0;
      r_bit_count <= 6'd0;
    end else if (w_sample) begin
      r_shift <= w_word[WIDTH-2:0];
      if (w_complete) begin
        r_bit_count <= 6'd0;
      end else begin
        r_bit_count <= r_bit_count + 6'd1;
      end
    end else begin
      // Deselected: any partial word is thrown away.
      r_shift     <= '0;
      r_bit_count <= 6'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output word and handshake. A completing word wins over an ack on the
  // same edge: the new word loads and stays valid, and since the consumer
  // did acknowledge the previous one, no overrun is recorded.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk_tck or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_complete) begin
        r_out   <= w_word;
        r_valid <= 1'b1;
      end else if (i_ack && r_valid) begin
        r_valid <= 1'b0;
      end

      if (w_complete && r_valid && !i_ack) begin
        r_overrun <= 1'b1;
      end else if (i_ack) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk_tck or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_abort;
    end
  end

  assign o_out       = r_out;
  assign o_valid     = r_valid;
  assign o_overrun   = r_overrun;
  assign o_aborted   = r_aborted;
  assign o_bit_count = r_bit_count;

endmodule

// File: tb/tb_byte_receiver.sv
module tb_byte_receiver;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         din = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] out;
  logic         valid;
  logic         overrun;
  logic         aborted;
  logic [5:0]   bc;

  always #5 clk = ~clk;

  byte_receiver #(.WIDTH(W)) dut (
    .i_clk_tck   (clk),
    .i_reset_n   (rst_n),
    .i_enable    (en),
    .i_in        (din),
    .i_ack       (ack),
    .o_out       (out),
    .o_valid     (valid),
    .o_overrun   (overrun),
    .o_aborted   (aborted),
    .o_bit_count (bc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the receiver, advanced once per tick.
  logic [W-1:0] m_sh;
  logic [W-1:0] m_out;
  logic         m_valid;
  logic         m_ovr;
  logic         m_abort;
  int           m_cnt;

  // Scoreboard: full words pushed when their shifting starts, popped when
  // the model says the word completes.
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] data;
    bit           ack_first;
    bit           ack_last;
    bit           exp_valid;
    bit           exp_ovr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_sh    = '0;
    m_out   = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_abort = 1'b0;
    m_cnt   = 0;
  endtask

  // Called at a falling edge; applies inputs for the next rising edge,
  // checks one time unit after it and returns at the following falling edge.
  task automatic tick(input logic e, input logic d, input logic a);
    bit           comp;
    logic [W-1:0] nsh;
    logic [W-1:0] w;
    en = e; din = d; ack = a;
    comp = 1'b0;
    nsh  = '0;
    m_abort = !e && (m_cnt != 0);
    if (e) begin
      nsh = {m_sh[W-2:0], d};
      if (m_cnt == W-1) begin
        comp  = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      m_cnt = 0;
    end
    if (comp && m_valid && !a) m_ovr = 1'b1;
    else if (a)                m_ovr = 1'b0;
    if (comp) begin
      m_out   = nsh;
      m_valid = 1'b1;
    end else if (a && m_valid) begin
      m_valid = 1'b0;
    end
    m_sh = nsh;

    @(posedge clk);
    #1;
    if (comp) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("sb_word", out, w);
      end
    end
    chk("cyc_out", out, m_out);
    chk("cyc_valid", {31'd0, valid}, {31'd0, m_valid});
    chk("cyc_overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("cyc_aborted", {31'd0, aborted}, {31'd0, m_abort});
    chk("cyc_bit_count", {26'd0, bc}, 32'(m_cnt));
    @(negedge clk);
  endtask

  task automatic shift_word(input logic [W-1:0] data, input bit af, input bit al);
    exp_q.push_back(data);
    for (int i = 0; i < W; i++)
      tick(1'b1, data[W-1-i], (i == 0 && af) || (i == W-1 && al));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; din = 1'b0; ack = 1'b0;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h12345678, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h9ABCDEF0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{32'h0F0F0F0F, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h80000001, 1'b1, 1'b0, 1'b1, 1'b0};

    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", out, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_aborted", {31'd0, aborted}, 32'd0);
    chk("rst_bit_count", {26'd0, bc}, 32'd0);
    rst_n = 1'b1;

    // Continuous back-to-back words: capture, ack-after-valid, overrun,
    // completion/ack collision.
    foreach (vecs[k]) begin
      shift_word(vecs[k].data, vecs[k].ack_first, vecs[k].ack_last);
      chk("vec_out", out, vecs[k].data);
      chk("vec_valid", {31'd0, valid}, {31'd0, vecs[k].exp_valid});
      chk("vec_overrun", {31'd0, overrun}, {31'd0, vecs[k].exp_ovr});
      chk("vec_bit_count", {26'd0, bc}, 32'd0);
    end

    // Dropping enable right after a completion is silent.
    tick(1'b0, 1'b0, 1'b0);
    chk("idle_no_abort", {31'd0, aborted}, 32'd0);

    // Abort mid-word.
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0);
    chk("abort_pre_count", {26'd0, bc}, 32'd10);
    tick(1'b0, 1'b0, 1'b0);
    chk("abort_pulse", {31'd0, aborted}, 32'd1);
    chk("abort_bit_count", {26'd0, bc}, 32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_out", out, 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("abort_one_cycle", {31'd0, aborted}, 32'd0);
    shift_word(32'h00000001, 1'b0, 1'b0);
    chk("after_abort_out", out, 32'h00000001);

    // Overrun, then ack clears both flags.
    do_reset();
    shift_word(32'h11111111, 1'b0, 1'b0);
    shift_word(32'h22222222, 1'b0, 1'b0);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_out", out, 32'h22222222);
    chk("ovr_valid", {31'd0, valid}, 32'd1);
    tick(1'b0, 1'b0, 1'b1);
    chk("ack_valid", {31'd0, valid}, 32'd0);
    chk("ack_overrun", {31'd0, overrun}, 32'd0);
    tick(1'b0, 1'b0, 1'b1);
    chk("ack_idle_ignored", {31'd0, valid}, 32'd0);

    // Asynchronous reset mid-word.
    do_reset();
    shift_word(32'h33333333, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) tick(1'b1, i[0], 1'b0);
    chk("pre_rst_count", {26'd0, bc}, 32'd17);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", out, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_overrun", {31'd0, overrun}, 32'd0);
    chk("arst_aborted", {31'd0, aborted}, 32'd0);
    chk("arst_bit_count", {26'd0, bc}, 32'd0);
    model_reset();
    exp_q.delete();
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    shift_word(32'hA5A5A5A5, 1'b0, 1'b0);
    chk("post_rst_out", out, 32'hA5A5A5A5);
    chk("post_rst_valid", {31'd0, valid}, 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
